// File: rtl/rv_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : rv_trace_capture
//  Description : Retire-trace recorder. Stores write-back retire records in a
//                circular buffer and serves them over a FWFT valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_trace_capture #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH_BITS       = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_retire_valid,
    input  logic [IADDR_SPACE_BITS-1:1]   i_retire_pc,
    input  logic [31:0]                   i_retire_instr,
    input  logic [31:0]                   i_retire_reg_data,
    input  logic [2:0]                    i_retire_flags,
    input  logic                          i_ctrl_arm,
    input  logic                          i_ctrl_stop,
    input  logic                          i_ctrl_clear,
    input  logic                          i_trig_en,
    input  logic [IADDR_SPACE_BITS-1:1]   i_trig_pc,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [IADDR_SPACE_BITS-1:1]   o_rd_pc,
    output logic [31:0]                   o_rd_instr,
    output logic [31:0]                   o_rd_data,
    output logic [2:0]                    o_rd_flags,
    output logic [1:0]                    o_state,
    output logic [DEPTH_BITS:0]           o_count,
    output logic [15:0]                   o_overflow
);

    localparam int                  c_PC_W  = IADDR_SPACE_BITS - 1;
    localparam int                  c_REC_W = c_PC_W + 32 + 32 + 3;
    localparam int                  c_DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] c_FULL  = (DEPTH_BITS + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [DEPTH_BITS:0]     r_count;
    logic [15:0]             r_overflow;
    logic [c_REC_W-1:0]      r_mem [c_DEPTH];

    logic                    w_clear;
    logic                    w_stop;
    logic                    w_arm;
    logic                    w_trig_hit;
    logic                    w_capture_en;
    logic                    w_write_req;
    logic                    w_full;
    logic                    w_write_acc;
    logic                    w_write_rej;
    logic                    w_rd_valid;
    logic                    w_pop;
    logic [c_REC_W-1:0]      w_wr_rec;
    logic [c_REC_W-1:0]      w_head;

    // Control priority: clear masks stop, stop masks arm.
    assign w_clear = i_ctrl_clear;
    assign w_stop  = i_ctrl_stop & ~i_ctrl_clear;
    assign w_arm   = i_ctrl_arm & ~i_ctrl_stop & ~i_ctrl_clear;

    assign w_trig_hit   = (r_state == ST_ARMED) && i_retire_valid && (i_retire_pc == i_trig_pc);
    assign w_capture_en = (r_state == ST_CAPTURE) || w_trig_hit;
    assign w_write_req  = i_retire_valid && w_capture_en && !w_clear && !w_stop;

    // Fullness is judged on the start-of-cycle count; a same-cycle pop does not free a slot.
    assign w_full      = (r_count == c_FULL);
    assign w_write_acc = w_write_req && !w_full;
    assign w_write_rej = w_write_req && w_full;

    assign w_rd_valid = (r_count != '0);
    assign w_pop      = w_rd_valid && i_rd_ready && !w_clear;

    assign w_wr_rec = {i_retire_pc, i_retire_instr, i_retire_reg_data, i_retire_flags};

    // ------------------------------------------------------------------
    // Session state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end else if (w_stop) begin
            if ((r_state == ST_ARMED) || (r_state == ST_CAPTURE)) begin
                w_state_next = ST_STOPPED;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_STOPPED: begin
                    if (w_arm) begin
                        w_state_next = i_trig_en ? ST_ARMED : ST_CAPTURE;
                    end
                end
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        w_state_next = ST_CAPTURE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and overflow
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write_acc) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_write_acc, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_BITS + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_BITS + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow <= '0;
        end else if (w_clear) begin
            r_overflow <= '0;
        end else if (w_write_rej && (r_overflow != 16'hFFFF)) begin
            r_overflow <= r_overflow + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Record storage (no reset: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_write_acc) begin
            r_mem[r_wr_ptr] <= w_wr_rec;
        end
    end

    assign w_head = w_rd_valid ? r_mem[r_rd_ptr] : '0;

    assign o_rd_valid = w_rd_valid;
    assign o_rd_pc    = w_head[c_REC_W-1 -: c_PC_W];
    assign o_rd_instr = w_head[66:35];
    assign o_rd_data  = w_head[34:3];
    assign o_rd_flags = w_head[2:0];
    assign o_state    = r_state;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire
